cmp_minmax_seq: RTL and testbench

- Frame-based min/max scheduler built around a single time-shared unsigned magnitude comparator.
- Accepts a stream of W-bit samples over a valid/ready handshake, grouped into frames by in_last.
- Each sample is sequenced through two comparison cycles: first against the running max, then against the running min.
- At frame end it presents max, min, their first-occurrence indices and the sample count over a valid/ready result handshake.

---
 rtl/cmp_minmax_seq.sv | 183 ++++++++++++++++++
 tb/tb_cmp_minmax_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_minmax_seq.sv
// Frame-based min/max tracker. One shared unsigned comparator is time-multiplexed:
// each accepted sample is compared against the running max, then against the running min.
module cmp_minmax_seq #(
   parameter int W     = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_max,
   output logic [W-1:0]     out_min,
   output logic [CNT_W-1:0] out_max_idx,
   output logic [CNT_W-1:0] out_min_idx,
   output logic [CNT_W:0]   out_count,
   output logic             out_trunc,
   output logic             busy
);

   // Handshakes: a transfer happens on the rising edge where valid and ready are both
   // high. in_ready and out_valid are registered and depend only on the state, so a
   // producer or consumer never sees them change combinationally with its own signals.

   typedef enum logic [1:0] {
      ACCEPT  = 2'd0,
      CMP_MAX = 2'd1,
      CMP_MIN = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] IDX_MAX = '1;

   state_t             state_q, state_d;
   logic               first_q, first_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic [W-1:0]       hold_q, hold_d;
   logic               last_q, last_d;
   logic [W-1:0]       max_q, max_d;
   logic [W-1:0]       min_q, min_d;
   logic [CNT_W-1:0]   max_idx_q, max_idx_d;
   logic [CNT_W-1:0]   min_idx_q, min_idx_d;
   logic [CNT_W:0]     count_q, count_d;
   logic               trunc_q, trunc_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   // Single comparator: one operand mux, one subtractor; the borrow gives hold > ref,
   // a non-zero difference without borrow gives hold < ref.
   logic [W-1:0]       cmp_ref;
   logic [W:0]         cmp_diff;
   logic               hold_gt;
   logic               hold_lt;

   always_comb begin
      cmp_ref  = (state_q == CMP_MAX) ? max_q : min_q;
      cmp_diff = {1'b0, cmp_ref} - {1'b0, hold_q};
      hold_gt  = cmp_diff[W];
      hold_lt  = !cmp_diff[W] && (cmp_diff[W-1:0] != '0);
   end

   always_comb begin
      state_d   = state_q;
      first_d   = first_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      last_d    = last_q;
      max_d     = max_q;
      min_d     = min_q;
      max_idx_d = max_idx_q;
      min_idx_d = min_idx_q;
      count_d   = count_q;
      trunc_d   = trunc_q;

      case (state_q)
         ACCEPT: begin
            if (in_valid && in_ready_q) begin
               hold_d  = in_data;
               last_d  = in_last || (idx_q == IDX_MAX);
               trunc_d = !in_last && (idx_q == IDX_MAX);
               if (first_q) begin
                  max_d     = in_data;
                  min_d     = in_data;
                  max_idx_d = '0;
                  min_idx_d = '0;
                  count_d   = (CNT_W+1)'(1);
                  first_d   = 1'b0;
                  if (in_last || (idx_q == IDX_MAX)) begin
                     state_d = DONE;
                  end else begin
                     // The first sample skips the comparator, so it advances idx itself.
                     idx_d = idx_q + CNT_W'(1);
                  end
               end else begin
                  count_d = count_q + (CNT_W+1)'(1);
                  state_d = CMP_MAX;
               end
            end
         end

         CMP_MAX: begin
            if (hold_gt) begin
               max_d     = hold_q;
               max_idx_d = idx_q;
            end
            state_d = CMP_MIN;
         end

         CMP_MIN: begin
            if (hold_lt) begin
               min_d     = hold_q;
               min_idx_d = idx_q;
            end
            idx_d   = idx_q + CNT_W'(1);
            state_d = last_q ? DONE : ACCEPT;
         end

         DONE: begin
            if (out_ready) begin
               first_d = 1'b1;
               idx_d   = '0;
               trunc_d = 1'b0;
               state_d = ACCEPT;
            end
         end

         default: state_d = ACCEPT;
      endcase

      in_ready_d  = (state_d == ACCEPT);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != ACCEPT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACCEPT;
         first_q     <= 1'b1;
         idx_q       <= '0;
         hold_q      <= '0;
         last_q      <= 1'b0;
         max_q       <= '0;
         min_q       <= '0;
         max_idx_q   <= '0;
         min_idx_q   <= '0;
         count_q     <= '0;
         trunc_q     <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         first_q     <= first_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         last_q      <= last_d;
         max_q       <= max_d;
         min_q       <= min_d;
         max_idx_q   <= max_idx_d;
         min_idx_q   <= min_idx_d;
         count_q     <= count_d;
         trunc_q     <= trunc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;
   assign out_max     = max_q;
   assign out_min     = min_q;
   assign out_max_idx = max_idx_q;
   assign out_min_idx = min_idx_q;
   assign out_count   = count_q;
   assign out_trunc   = trunc_q;

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Directed bench for cmp_minmax_seq: one instance at CNT_W=8, one at CNT_W=2 for
// truncation, plus a randomised frame run against a scoreboard.
module tb_cmp_minmax_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default widths
  logic        in_valid_a = 1'b0, in_last_a = 1'b0, out_ready_a = 1'b1;
  logic [15:0] in_data_a = '0;
  logic        in_ready_a, out_valid_a, out_trunc_a, busy_a;
  logic [15:0] out_max_a, out_min_a;
  logic [7:0]  out_max_idx_a, out_min_idx_a;
  logic [8:0]  out_count_a;

  // Instance B: CNT_W=2, frames cut at 4 samples
  logic        in_valid_b = 1'b0, in_last_b = 1'b0, out_ready_b = 1'b1;
  logic [15:0] in_data_b = '0;
  logic        in_ready_b, out_valid_b, out_trunc_b, busy_b;
  logic [15:0] out_max_b, out_min_b;
  logic [1:0]  out_max_idx_b, out_min_idx_b;
  logic [2:0]  out_count_b;

  cmp_minmax_seq #(.W(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a), .in_last(in_last_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_max(out_max_a), .out_min(out_min_a),
    .out_max_idx(out_max_idx_a), .out_min_idx(out_min_idx_a),
    .out_count(out_count_a), .out_trunc(out_trunc_a), .busy(busy_a)
  );

  cmp_minmax_seq #(.W(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b), .in_last(in_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_max(out_max_b), .out_min(out_min_b),
    .out_max_idx(out_max_idx_b), .out_min_idx(out_min_idx_b),
    .out_count(out_count_b), .out_trunc(out_trunc_b), .busy(busy_b)
  );

  logic [57:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic send_a(input logic [15:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) check("send_a_timeout", 64'(in_ready_a), 64'(1));
    in_valid_a = 1'b1;
    in_data_a  = d;
    in_last_a  = l;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    in_last_a  = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_b) check("send_b_timeout", 64'(in_ready_b), 64'(1));
    in_valid_b = 1'b1;
    in_data_b  = d;
    in_last_b  = l;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    in_last_b  = 1'b0;
  endtask

  // Returns the cycle counter value at the edge after which out_valid was first seen.
  task automatic wait_valid_a(output int at);
    int n = 0;
    while (!out_valid_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid_a) check("valid_a_timeout", 64'(out_valid_a), 64'(1));
    at = cyc;
  endtask

  task automatic wait_valid_b();
    int n = 0;
    while (!out_valid_b && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid_b) check("valid_b_timeout", 64'(out_valid_b), 64'(1));
  endtask

  initial begin
    int hs, at, seen, got;
    logic [58:0] stall_exp;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready_a), 64'(1));
    check("rst_out_valid", 64'(out_valid_a), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_result", 64'({out_max_a, out_min_a, out_count_a}), 64'(0));

    // Frame 5,9,2,9,2: cycle index of out_valid counts the handshake cycle as 0
    send_a(16'd5, 1'b0);
    hs = cyc;
    send_a(16'd9, 1'b0);
    send_a(16'd2, 1'b0);
    send_a(16'd9, 1'b0);
    send_a(16'd2, 1'b1);
    wait_valid_a(at);
    check("f1_latency", 64'(at - hs + 1), 64'(13));
    check("f1_max", 64'(out_max_a), 64'(9));
    check("f1_max_idx", 64'(out_max_idx_a), 64'(1));
    check("f1_min", 64'(out_min_a), 64'(2));
    check("f1_min_idx", 64'(out_min_idx_a), 64'(2));
    check("f1_count", 64'(out_count_a), 64'(5));
    check("f1_trunc", 64'(out_trunc_a), 64'(0));

    // Single-sample frame
    send_a(16'hFFFF, 1'b1);
    hs = cyc;
    wait_valid_a(at);
    check("f2_latency", 64'(at - hs + 1), 64'(1));
    check("f2_max_min", 64'({out_max_a, out_min_a}), 64'({16'hFFFF, 16'hFFFF}));
    check("f2_idx", 64'({out_max_idx_a, out_min_idx_a}), 64'(0));
    check("f2_count", 64'(out_count_a), 64'(1));

    // Stalled result: 7,7,3 -> max 7 @0, min 3 @2, count 3
    send_a(16'd7, 1'b0);
    out_ready_a = 1'b0;
    send_a(16'd7, 1'b0);
    send_a(16'd3, 1'b1);
    wait_valid_a(at);
    stall_exp = {1'b1, 1'b0, 16'd7, 16'd3, 8'd0, 8'd2, 9'd3};
    for (int i = 0; i < 10; i++) begin
      check("stall_hold", 64'({out_valid_a, in_ready_a, out_max_a, out_min_a,
                               out_max_idx_a, out_min_idx_a, out_count_a}), 64'(stall_exp));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", 64'(out_valid_a), 64'(0));
    check("release_in_ready", 64'(in_ready_a), 64'(1));
    send_a(16'd6, 1'b0);
    send_a(16'd8, 1'b1);
    wait_valid_a(at);
    check("f4_max", 64'({out_max_a, out_max_idx_a}), 64'({16'd8, 8'd1}));
    check("f4_min", 64'({out_min_a, out_min_idx_a}), 64'({16'd6, 8'd0}));

    // Truncation with CNT_W=2
    send_b(16'd1, 1'b0);
    send_b(16'd2, 1'b0);
    send_b(16'd3, 1'b0);
    send_b(16'd4, 1'b0);
    wait_valid_b();
    check("t1_max", 64'({out_max_b, out_max_idx_b}), 64'({16'd4, 2'd3}));
    check("t1_min", 64'({out_min_b, out_min_idx_b}), 64'({16'd1, 2'd0}));
    check("t1_count", 64'(out_count_b), 64'(4));
    check("t1_trunc", 64'(out_trunc_b), 64'(1));
    send_b(16'd0, 1'b0);
    send_b(16'd7, 1'b1);
    wait_valid_b();
    check("t2_min", 64'({out_min_b, out_min_idx_b}), 64'({16'd0, 2'd0}));
    check("t2_max", 64'({out_max_b, out_max_idx_b}), 64'({16'd7, 2'd1}));
    check("t2_count", 64'(out_count_b), 64'(2));
    check("t2_trunc", 64'(out_trunc_b), 64'(0));

    // Reset during CMP_MAX of the third sample
    send_a(16'd10, 1'b0);
    send_a(16'd20, 1'b0);
    send_a(16'd30, 1'b0);
    check("pre_rst_busy", 64'(busy_a), 64'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready_a), 64'(1));
    check("mid_rst_out_valid", 64'(out_valid_a), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid_a) seen++;
    end
    check("rst_no_result", 64'(seen), 64'(0));
    send_a(16'd4, 1'b0);
    send_a(16'd3, 1'b1);
    wait_valid_a(at);
    check("r1_max", 64'({out_max_a, out_max_idx_a}), 64'({16'd4, 8'd0}));
    check("r1_min", 64'({out_min_a, out_min_idx_a}), 64'({16'd3, 8'd1}));
    check("r1_count", 64'(out_count_a), 64'(2));
    @(posedge clk);
    #1;

    // Randomised frames with input gaps and output stalls
    got = 0;
    fork
      begin : driver
        for (int f = 0; f < 50; f++) begin
          logic [15:0] v[8];
          logic [15:0] mx, mn;
          logic [7:0]  mxi, mni;
          int len;
          len = $urandom_range(1, 7);
          for (int i = 0; i < len; i++)
            v[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                               : 16'($urandom_range(0, 7));
          mx = v[0]; mn = v[0]; mxi = 0; mni = 0;
          for (int i = 1; i < len; i++) begin
            if (v[i] > mx) begin mx = v[i]; mxi = 8'(i); end
            if (v[i] < mn) begin mn = v[i]; mni = 8'(i); end
          end
          exp_q.push_back({mx, mn, mxi, mni, 9'(len), 1'b0});
          for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_a(v[i], i == len - 1);
          end
        end
      end
      begin : monitor
        int n = 0;
        while (got < 50 && n < 20000) begin
          @(negedge clk);
          n++;
          out_ready_a = ($urandom_range(0, 2) != 0);
          if (out_valid_a && out_ready_a) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected", 64'(out_valid_a), 64'(0));
            end else begin
              check("rand_result", 64'({out_max_a, out_min_a, out_max_idx_a, out_min_idx_a,
                                        out_count_a, out_trunc_a}), 64'(exp_q.pop_front()));
            end
            got++;
          end
        end
      end
    join
    out_ready_a = 1'b1;
    check("rand_result_count", 64'(got), 64'(50));
    check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
